// File: rtl/demux_tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer: FSM encoding and
// timeout counter sizing.
package demux_tdm_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int TMO_DEF = 255;

   function automatic int f_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

   localparam int TMO_W_DEF = f_clog2(TMO_DEF + 1);

endpackage

// File: rtl/demux_slot_ctr.sv
// Slot index (Sel) counter plus inter-strobe timeout counter that saturates
// at TMO; o_tmo_hit flags the edge on which the count would reach TMO.
module demux_slot_ctr #(
   parameter int SEL_W = 2,
   parameter int TMO   = 255,
   parameter int TMO_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_sel_ld1,
   input  logic             i_sel_clr,
   input  logic             i_sel_inc,
   input  logic             i_tmo_clr,
   input  logic             i_tmo_en,
   output logic [SEL_W-1:0] o_sel,
   output logic             o_tmo_hit
);

   logic [SEL_W-1:0] r_sel;
   logic [TMO_W-1:0] r_tmo;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sel <= '0;
         r_tmo <= '0;
      end else begin
         if (i_sel_ld1)
            r_sel <= SEL_W'(1);
         else if (i_sel_clr)
            r_sel <= '0;
         else if (i_sel_inc)
            r_sel <= r_sel + SEL_W'(1);

         if (i_tmo_clr)
            r_tmo <= '0;
         else if (i_tmo_en && (r_tmo != TMO_W'(TMO)))
            r_tmo <= r_tmo + TMO_W'(1);
      end
   end

   assign o_sel     = r_sel;
   assign o_tmo_hit = i_tmo_en && (r_tmo == TMO_W'(TMO - 1));

endmodule

// File: rtl/demux_tdm.sv
// TDM receive demultiplexer: regenerates the slot select, collects one bit
// per strobe and publishes each complete frame with a one-cycle valid pulse.
module demux_tdm
   import demux_tdm_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int SEL_W = 2,
   parameter int TMO   = TMO_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ent,
   input  logic             i_smp,
   input  logic             i_sync,
   output logic [N_CH-1:0]  o_sal,
   output logic [SEL_W-1:0] o_sel,
   output logic             o_vld,
   output logic             o_err
);

   localparam int TMO_W = f_clog2(TMO + 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

   state_t          r_state;
   logic [N_CH-2:0] r_shadow;
   logic [N_CH-1:0] r_sal;
   logic            r_vld;
   logic            r_err;

   logic [SEL_W-1:0] w_sel;
   logic             w_tmo_hit;
   logic             w_run;
   logic             w_data;
   logic             w_start;
   logic             w_resync;
   logic             w_lost;
   logic             w_last;
   logic             w_mid;
   logic             w_tmo_abort;

   assign w_run       = (r_state == ST_RUN);
   assign w_data      = w_run && i_smp && !i_sync;
   // A Sync strobe always (re)starts a frame, whether hunting or mid-frame.
   assign w_start     = i_smp && i_sync;
   assign w_resync    = w_run && w_start && (w_sel != '0);
   assign w_lost      = w_data && (w_sel == '0);
   assign w_last      = w_data && (w_sel == SEL_LAST);
   assign w_mid       = w_data && (w_sel != '0) && (w_sel != SEL_LAST);
   assign w_tmo_abort = w_run && !i_smp && w_tmo_hit && (w_sel != '0);

   demux_slot_ctr #(
      .SEL_W (SEL_W),
      .TMO   (TMO),
      .TMO_W (TMO_W)
   ) u_slot_ctr (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_sel_ld1 (w_start),
      .i_sel_clr (w_lost || w_last || w_tmo_abort),
      .i_sel_inc (w_mid),
      .i_tmo_clr (!w_run || i_smp),
      .i_tmo_en  (w_run),
      .o_sel     (w_sel),
      .o_tmo_hit (w_tmo_hit)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_shadow <= '0;
         r_sal    <= '0;
         r_vld    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_vld <= 1'b0;
         r_err <= 1'b0;
         if (w_start) begin
            r_shadow[0] <= i_ent;
            r_state     <= ST_RUN;
            r_err       <= w_resync;
         end else if (w_mid) begin
            r_shadow[w_sel] <= i_ent;
         end else if (w_last) begin
            r_sal <= {i_ent, r_shadow};
            r_vld <= 1'b1;
         end else if (w_lost || w_tmo_abort) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
         end
      end
   end

   assign o_sal = r_sal;
   assign o_sel = w_sel;
   assign o_vld = r_vld;
   assign o_err = r_err;

endmodule

// File: tb/tb_demux_tdm.sv
// Directed bench for demux_tdm: framing, resync, alignment loss, timeout
// and mid-frame reset, with hand-computed expectations.
module tb_demux_tdm;

   localparam int N_CH  = 4;
   localparam int SEL_W = 2;
   localparam int TMO   = 255;

   logic             clk;
   logic             i_rst;
   logic             i_ent;
   logic             i_smp;
   logic             i_sync;
   logic [N_CH-1:0]  o_sal;
   logic [SEL_W-1:0] o_sel;
   logic             o_vld;
   logic             o_err;

   int n_checks;
   int n_fail;

   demux_tdm #(.N_CH(N_CH), .SEL_W(SEL_W), .TMO(TMO)) dut (
      .i_clk  (clk),
      .i_rst  (i_rst),
      .i_ent  (i_ent),
      .i_smp  (i_smp),
      .i_sync (i_sync),
      .o_sal  (o_sal),
      .o_sel  (o_sel),
      .o_vld  (o_vld),
      .o_err  (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are held across the next rising edge; outputs are read 1 time unit later.
   task automatic drive(input logic smp, input logic sync, input logic ent);
      i_smp  = smp;
      i_sync = sync;
      i_ent  = ent;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [3:0] d, input int gap);
      for (int k = 0; k < N_CH; k++) begin
         drive(1'b1, (k == 0), d[k]);
         if (k == N_CH - 1) begin
            chk("frame_vld", o_vld, 1);
            chk("frame_sal", o_sal, d);
            chk("frame_err", o_err, 0);
            chk("frame_sel_wrap", o_sel, 0);
         end else begin
            chk("frame_sel", o_sel, k + 1);
            chk("frame_vld_mid", o_vld, 0);
            for (int g = 0; g < gap; g++) begin
               drive(1'b0, 1'b0, 1'b0);
               chk("gap_sel_hold", o_sel, k + 1);
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0);
      chk("vld_pulse_end", o_vld, 0);
      chk("sal_hold", o_sal, d);
   endtask

   initial begin
      logic seen;
      n_checks = 0;
      n_fail   = 0;
      i_rst    = 1'b1;
      i_ent    = 1'b0;
      i_smp    = 1'b0;
      i_sync   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sal", o_sal, 0);
      chk("rst_sel", o_sel, 0);
      chk("rst_vld", o_vld, 0);
      chk("rst_err", o_err, 0);
      i_rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: back-to-back strobes, Ent=1,0,1,1
      send_frame(4'b1101, 0);

      // 2: strobe every third cycle, two frames
      send_frame(4'hA, 2);
      send_frame(4'h5, 2);

      // 3: Sync at slot 2 resyncs and restarts the frame
      drive(1'b1, 1'b1, 1'b0);
      chk("rs_sel1", o_sel, 1);
      drive(1'b1, 1'b0, 1'b1);
      chk("rs_sel2", o_sel, 2);
      drive(1'b1, 1'b1, 1'b1);
      chk("rs_err", o_err, 1);
      chk("rs_sel", o_sel, 1);
      chk("rs_vld", o_vld, 0);
      drive(1'b1, 1'b0, 1'b1);
      chk("rs_err_clr", o_err, 0);
      drive(1'b1, 1'b0, 1'b1);
      chk("rs_sel3", o_sel, 3);
      drive(1'b1, 1'b0, 1'b0);
      chk("rs_vld_done", o_vld, 1);
      chk("rs_sal", o_sal, 4'b0111);

      // 4: missing Sync at slot 0 -> Err, IDLE ignores unsynced strobes
      drive(1'b1, 1'b0, 1'b1);
      chk("lost_err", o_err, 1);
      chk("lost_sel", o_sel, 0);
      drive(1'b1, 1'b0, 1'b1);
      chk("hunt_no_err", o_err, 0);
      chk("hunt_sel", o_sel, 0);
      send_frame(4'h3, 0);

      // between frames the timeout saturates silently
      seen = 1'b0;
      for (int i = 0; i < TMO + 40; i++) begin
         drive(1'b0, 1'b0, 1'b0);
         if (o_err) seen = 1'b1;
      end
      chk("idle_sat_no_err", seen, 0);

      // 5: strobes stop at Sel=2
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      chk("tmo_sel2", o_sel, 2);
      seen = 1'b0;
      for (int i = 1; i < TMO; i++) begin
         drive(1'b0, 1'b0, 1'b0);
         if (o_err) seen = 1'b1;
      end
      chk("tmo_early", seen, 0);
      chk("tmo_sel_before", o_sel, 2);
      drive(1'b0, 1'b0, 1'b0);
      chk("tmo_err", o_err, 1);
      chk("tmo_sel0", o_sel, 0);
      chk("tmo_sal_keep", o_sal, 4'h3);
      chk("tmo_vld", o_vld, 0);
      drive(1'b1, 1'b0, 1'b0);
      chk("tmo_idle_ignore", o_err, 0);

      // 6: reset mid-frame
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      chk("pre_rst_sel3", o_sel, 3);
      i_smp = 1'b0;
      i_rst = 1'b1;
      #1;
      chk("async_rst_sal", o_sal, 0);
      chk("async_rst_sel", o_sel, 0);
      chk("async_rst_vld", o_vld, 0);
      chk("async_rst_err", o_err, 0);
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      send_frame(4'h9, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
